// File: rtl/clk_div_bank.sv
// clk_div_bank
// Multi-output integer clock divider with per-channel phase offset, a
// one-refclk strobe on every rising edge of each output, and a lock flag
// that rises once the bank has run LOCK_CYCLES edges since the last
// (re)alignment.
//
// Ports:
//   i_refclk       reference clock, all logic on its rising edge
//   i_rst          asynchronous active-high reset
//   i_sync         synchronous re-align, holds every channel at its start point
//   i_ena          count enable, low freezes all channels
//   o_outclk       divided clocks, registered
//   o_outclk_stb   one-refclk pulse coincident with each rising edge of o_outclk
//   o_locked       high once alignment has been stable for LOCK_CYCLES edges
module clk_div_bank #(
    parameter int unsigned                   NUM_CLKS    = 2,
    parameter int unsigned                   CNT_W       = 16,
    parameter logic [NUM_CLKS*CNT_W-1:0]     DIVS        = {16'd3, 16'd4},
    parameter logic [NUM_CLKS*CNT_W-1:0]     PHASES      = {16'd1, 16'd0},
    parameter int unsigned                   LOCK_CYCLES = 16
) (
    input  logic                i_refclk,
    input  logic                i_rst,
    input  logic                i_sync,
    input  logic                i_ena,
    output logic [NUM_CLKS-1:0] o_outclk,
    output logic [NUM_CLKS-1:0] o_outclk_stb,
    output logic                o_locked
);

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CLKS; k++) begin : g_chan
        localparam logic [CNT_W-1:0] RAW_DIV = DIVS[k*CNT_W +: CNT_W];
        localparam logic [CNT_W-1:0] DIV_EFF = (RAW_DIV < CNT_W'(2)) ? CNT_W'(2) : RAW_DIV;
        localparam logic [CNT_W-1:0] PHASE   = PHASES[k*CNT_W +: CNT_W] % DIV_EFF;
        localparam logic [CNT_W-1:0] HI_LEN  = DIV_EFF >> 1;
        // Preloading D-P makes the counter reach 0 (the rising edge) on
        // enabled edge number PHASE after start.
        localparam logic [CNT_W-1:0] PRELOAD = (PHASE == '0) ? '0 : (DIV_EFF - PHASE);
        localparam logic [CNT_W-1:0] CNT_TOP = DIV_EFF - CNT_W'(1);

        logic [CNT_W-1:0] r_cnt;
        logic             r_clk;
        logic             r_stb;

        always_ff @(posedge i_refclk or posedge i_rst) begin
            if (i_rst) begin
                r_cnt <= PRELOAD;
                r_clk <= 1'b0;
                r_stb <= 1'b0;
            end else if (i_sync) begin
                r_cnt <= PRELOAD;
                r_clk <= 1'b0;
                r_stb <= 1'b0;
            end else if (i_ena) begin
                // Outputs are decoded from the pre-edge count and registered,
                // so the output pins never see a combinational glitch.
                r_clk <= (r_cnt < HI_LEN);
                r_stb <= (r_cnt == '0);
                r_cnt <= (r_cnt == CNT_TOP) ? '0 : (r_cnt + CNT_W'(1));
            end else begin
                r_stb <= 1'b0;
            end
        end

        assign o_outclk[k]     = r_clk;
        assign o_outclk_stb[k] = r_stb;
    end

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    localparam logic [1:0] S_HOLD   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    // Wraps to 8'hFF when LOCK_CYCLES is 0; SETTLE is skipped in that case.
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_lock_cnt;
    logic       r_locked;
    logic [1:0] w_state_nxt;
    logic [7:0] w_lock_cnt_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (i_sync) begin
            w_state_nxt    = S_HOLD;
            w_lock_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_lock_cnt_nxt = '0;
                    w_state_nxt    = (LOCK_CYCLES == 0) ? S_LOCKED : S_SETTLE;
                end
                S_SETTLE: begin
                    // Counts every non-sync edge regardless of i_ena.
                    if (r_lock_cnt == LOCK_LAST) begin
                        w_state_nxt = S_LOCKED;
                    end
                    if (r_lock_cnt != 8'hFF) begin
                        w_lock_cnt_nxt = r_lock_cnt + 8'd1;
                    end
                end
                S_LOCKED: begin
                    w_state_nxt = S_LOCKED;
                end
                default: begin
                    w_state_nxt    = S_HOLD;
                    w_lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_HOLD;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (w_state_nxt == S_LOCKED);
        end
    end

    assign o_locked = r_locked;

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

    logic refclk = 1'b0;
    logic rst;
    logic sync;
    logic ena;

    // default-parameter instance
    logic [1:0] oc;
    logic [1:0] st;
    logic       lk;
    // LOCK_CYCLES = 0 instance
    logic [1:0] oc_z;
    logic [1:0] st_z;
    logic       lk_z;
    // boundary-parameter instance
    logic [2:0] oc3;
    logic [2:0] st3;
    logic       lk3;

    always #5 refclk = ~refclk;

    clk_div_bank #(
        .NUM_CLKS(2), .CNT_W(16),
        .DIVS({16'd3, 16'd4}), .PHASES({16'd1, 16'd0}),
        .LOCK_CYCLES(16)
    ) u_dflt (
        .i_refclk(refclk), .i_rst(rst), .i_sync(sync), .i_ena(ena),
        .o_outclk(oc), .o_outclk_stb(st), .o_locked(lk)
    );

    clk_div_bank #(
        .NUM_CLKS(2), .CNT_W(16),
        .DIVS({16'd3, 16'd4}), .PHASES({16'd1, 16'd0}),
        .LOCK_CYCLES(0)
    ) u_lz (
        .i_refclk(refclk), .i_rst(rst), .i_sync(sync), .i_ena(ena),
        .o_outclk(oc_z), .o_outclk_stb(st_z), .o_locked(lk_z)
    );

    // ch0 DIV 2, ch1 DIV 1 (treated as 2), ch2 DIV 5 with PHASE 7 (acts as 2)
    clk_div_bank #(
        .NUM_CLKS(3), .CNT_W(16),
        .DIVS({16'd5, 16'd1, 16'd2}), .PHASES({16'd7, 16'd0, 16'd0}),
        .LOCK_CYCLES(5)
    ) u_bnd (
        .i_refclk(refclk), .i_rst(rst), .i_sync(sync), .i_ena(ena),
        .o_outclk(oc3), .o_outclk_stb(st3), .o_locked(lk3)
    );

    typedef struct {
        logic [1:0] oc;
        logic [1:0] st;
        logic       lk;
        logic       lkz;
        logic [2:0] oc3;
        logic [2:0] st3;
        logic       lk3;
    } exp_t;

    exp_t sb[$];
    exp_t m_cur;
    int   m_t;
    int   m_s;
    int   total = 0;
    int   bad   = 0;

    // Literal first-scenario pattern, bit i = edge t_i.
    logic [5:0] lit_oc0 = 6'b110011;
    logic [5:0] lit_st0 = 6'b010001;
    logic [5:0] lit_oc1 = 6'b010010;
    logic [5:0] lit_st1 = 6'b010010;

    // Reference channel behaviour: rising edge at t = PHASE mod D.
    function automatic void chan(input int div, input int ph, input int t,
                                 output logic o, output logic s);
        int d;
        int p;
        int idx;
        d   = (div < 2) ? 2 : div;
        p   = ph % d;
        idx = ((t % d) + d - p) % d;
        o   = (idx < (d / 2));
        s   = (idx == 0);
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_s = 0;
        m_cur = '{default: '0};
    endtask

    // Drive one edge's inputs, push its expectation, wait past the edge.
    task automatic tick(input logic e, input logic sy, input bit use_lit, input int li);
        exp_t x;
        logic o;
        logic s;
        ena  = e;
        sync = sy;
        if (sy) begin
            model_reset();
        end else begin
            m_cur.lk  = (m_s >= 16);
            m_cur.lkz = 1'b1;
            m_cur.lk3 = (m_s >= 5);
            m_s++;
            if (e) begin
                chan(4, 0, m_t, o, s); m_cur.oc[0]  = o; m_cur.st[0]  = s;
                chan(3, 1, m_t, o, s); m_cur.oc[1]  = o; m_cur.st[1]  = s;
                chan(2, 0, m_t, o, s); m_cur.oc3[0] = o; m_cur.st3[0] = s;
                chan(1, 0, m_t, o, s); m_cur.oc3[1] = o; m_cur.st3[1] = s;
                chan(5, 7, m_t, o, s); m_cur.oc3[2] = o; m_cur.st3[2] = s;
                m_t++;
            end else begin
                m_cur.st  = '0;
                m_cur.st3 = '0;
            end
        end
        x = m_cur;
        if (use_lit) begin
            x.oc  = {lit_oc1[li], lit_oc0[li]};
            x.st  = {lit_st1[li], lit_st0[li]};
            x.lk  = 1'b0;
            x.lkz = 1'b1;
        end
        sb.push_back(x);
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sync = 1'b0;
        ena  = 1'b1;
        @(posedge refclk);
        #1;
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        sync = 1'b0;
        ena  = 1'b1;
        repeat (2) @(posedge refclk);
        #1;
        total++; if (oc !== 2'b00)  begin bad++; $display("FAIL reset_oc: got %b want 00", oc); end
        total++; if (st !== 2'b00)  begin bad++; $display("FAIL reset_st: got %b want 00", st); end
        total++; if (lk !== 1'b0)   begin bad++; $display("FAIL reset_lk: got %b want 0", lk); end
        total++; if (lk_z !== 1'b0) begin bad++; $display("FAIL reset_lkz: got %b want 0", lk_z); end
        total++; if (oc3 !== 3'b000) begin bad++; $display("FAIL reset_oc3: got %b want 000", oc3); end
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic test_free_run();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b1, i);
            e = sb.pop_front();
            total++; if (oc !== e.oc)   begin bad++; $display("FAIL free_oc t%0d: got %b want %b", i, oc, e.oc); end
            total++; if (st !== e.st)   begin bad++; $display("FAIL free_st t%0d: got %b want %b", i, st, e.st); end
            total++; if (oc_z !== e.oc) begin bad++; $display("FAIL free_oc_z t%0d: got %b want %b", i, oc_z, e.oc); end
            total++; if (st_z !== e.st) begin bad++; $display("FAIL free_st_z t%0d: got %b want %b", i, st_z, e.st); end
            total++; if (lk !== e.lk)   begin bad++; $display("FAIL free_lk t%0d: got %b want %b", i, lk, e.lk); end
            total++; if (lk_z !== e.lkz) begin bad++; $display("FAIL free_lkz t%0d: got %b want %b", i, lk_z, e.lkz); end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        for (int i = 6; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, 0);
            e = sb.pop_front();
            total++; if (lk !== e.lk)    begin bad++; $display("FAIL lock_lk t%0d: got %b want %b", i, lk, e.lk); end
            total++; if (lk_z !== e.lkz) begin bad++; $display("FAIL lock_lkz t%0d: got %b want %b", i, lk_z, e.lkz); end
            total++; if (oc !== e.oc)    begin bad++; $display("FAIL lock_oc t%0d: got %b want %b", i, oc, e.oc); end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 1'b0, 0);
            e = sb.pop_front();
            total++; if (oc !== e.oc) begin bad++; $display("FAIL sync_pre_oc t%0d: got %b want %b", i, oc, e.oc); end
        end
        tick(1'b1, 1'b1, 1'b0, 0);
        e = sb.pop_front();
        total++; if (oc !== e.oc)     begin bad++; $display("FAIL sync_edge_oc: got %b want %b", oc, e.oc); end
        total++; if (st !== e.st)     begin bad++; $display("FAIL sync_edge_st: got %b want %b", st, e.st); end
        total++; if (lk_z !== e.lkz)  begin bad++; $display("FAIL sync_edge_lkz: got %b want %b", lk_z, e.lkz); end
        total++; if (oc3 !== e.oc3)   begin bad++; $display("FAIL sync_edge_oc3: got %b want %b", oc3, e.oc3); end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b1, i);
            e = sb.pop_front();
            total++; if (oc !== e.oc)    begin bad++; $display("FAIL sync_re_oc t%0d: got %b want %b", i, oc, e.oc); end
            total++; if (st !== e.st)    begin bad++; $display("FAIL sync_re_st t%0d: got %b want %b", i, st, e.st); end
            total++; if (lk_z !== e.lkz) begin bad++; $display("FAIL sync_re_lkz t%0d: got %b want %b", i, lk_z, e.lkz); end
        end
        for (int i = 6; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, 0);
            e = sb.pop_front();
            total++; if (lk !== e.lk) begin bad++; $display("FAIL sync_re_lk t%0d: got %b want %b", i, lk, e.lk); end
        end
    endtask

    task automatic test_ena_gap();
        exp_t e;
        logic en;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            en = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
            tick(en, 1'b0, 1'b0, 0);
            e = sb.pop_front();
            total++; if (oc !== e.oc)   begin bad++; $display("FAIL gap_oc t%0d: got %b want %b", i, oc, e.oc); end
            total++; if (st !== e.st)   begin bad++; $display("FAIL gap_st t%0d: got %b want %b", i, st, e.st); end
            total++; if (lk !== e.lk)   begin bad++; $display("FAIL gap_lk t%0d: got %b want %b", i, lk, e.lk); end
            total++; if (oc3 !== e.oc3) begin bad++; $display("FAIL gap_oc3 t%0d: got %b want %b", i, oc3, e.oc3); end
        end
    endtask

    task automatic test_boundary();
        exp_t e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 0);
            e = sb.pop_front();
            total++; if (oc3 !== e.oc3) begin bad++; $display("FAIL bnd_oc3 t%0d: got %b want %b", i, oc3, e.oc3); end
            total++; if (st3 !== e.st3) begin bad++; $display("FAIL bnd_st3 t%0d: got %b want %b", i, st3, e.st3); end
            total++; if (lk3 !== e.lk3) begin bad++; $display("FAIL bnd_lk3 t%0d: got %b want %b", i, lk3, e.lk3); end
            if (i < 3) begin
                total++;
                if (oc3[2] !== (i == 2)) begin
                    bad++; $display("FAIL bnd_first_rise t%0d: got %b want %b", i, oc3[2], (i == 2));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b0, 1'b0, 0);
            e = sb.pop_front();
            total++; if (oc !== e.oc) begin bad++; $display("FAIL ar_pre_oc t%0d: got %b want %b", i, oc, e.oc); end
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (oc !== 2'b00)   begin bad++; $display("FAIL ar_oc: got %b want 00", oc); end
        total++; if (st !== 2'b00)   begin bad++; $display("FAIL ar_st: got %b want 00", st); end
        total++; if (lk_z !== 1'b0)  begin bad++; $display("FAIL ar_lkz: got %b want 0", lk_z); end
        total++; if (oc3 !== 3'b000) begin bad++; $display("FAIL ar_oc3: got %b want 000", oc3); end
        total++; if (lk3 !== 1'b0)   begin bad++; $display("FAIL ar_lk3: got %b want 0", lk3); end
        rst = 1'b0;
        model_reset();
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b1, i);
            e = sb.pop_front();
            total++; if (oc !== e.oc)    begin bad++; $display("FAIL ar_re_oc t%0d: got %b want %b", i, oc, e.oc); end
            total++; if (st !== e.st)    begin bad++; $display("FAIL ar_re_st t%0d: got %b want %b", i, st, e.st); end
            total++; if (lk !== e.lk)    begin bad++; $display("FAIL ar_re_lk t%0d: got %b want %b", i, lk, e.lk); end
            total++; if (lk_z !== e.lkz) begin bad++; $display("FAIL ar_re_lkz t%0d: got %b want %b", i, lk_z, e.lkz); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        sync = 1'b0;
        ena  = 1'b1;
        model_reset();
        test_reset();
        test_free_run();
        test_lock();
        test_sync();
        test_ena_gap();
        test_boundary();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
